// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO and its consumers.
package fifo_pkg;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

   // Bits needed to hold an occupancy of 0..depth inclusive.
   function automatic int unsigned clog2_cnt(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Accept logic, wrapping pointers, occupancy count and registered status flags.
module fifo_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned AF_LVL = 6,
   parameter int unsigned AE_LVL = 1,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = clog2_cnt(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             write,
   input  logic             read,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [CNT_W-1:0] count,
   output fifo_status_t     status,
   output logic             wr_acc_c
);

   localparam fifo_status_t STATUS_RST = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                                           almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0};

   logic             rd_acc_c;
   logic [CNT_W-1:0] count_nxt;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      rd_acc_c  = 1'b0;
      wr_acc_c  = 1'b0;
      count_nxt = count;
      if (!rst && !flush) begin
         rd_acc_c = read & ~status.empty;
         wr_acc_c = write & (~status.full | rd_acc_c);
      end
      if (wr_acc_c && !rd_acc_c) begin
         count_nxt = count + CNT_W'(1);
      end else if (!wr_acc_c && rd_acc_c) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         status <= STATUS_RST;
      end else begin
         if (wr_acc_c) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_acc_c) rd_ptr <= ptr_inc(rd_ptr);
         count               <= count_nxt;
         status.full         <= (count_nxt == CNT_W'(DEPTH));
         status.empty        <= (count_nxt == '0);
         status.almost_full  <= (count_nxt >= CNT_W'(AF_LVL));
         status.almost_empty <= (count_nxt <= CNT_W'(AE_LVL));
         status.overflow     <= status.overflow | (write & ~wr_acc_c);
         status.underflow    <= status.underflow | (read & ~rd_acc_c);
      end
   end

endmodule

// File: rtl/fifobuff_param.sv
// Parametrised synchronous FIFO: storage array plus FWFT or registered read port.
module fifobuff_param
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W = 3,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned AF_LVL = 6,
   parameter int unsigned AE_LVL = 1,
   parameter int unsigned FWFT   = 1,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = clog2_cnt(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              write,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              read,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              underflow
);

   if (!(AE_LVL < AF_LVL && AF_LVL <= DEPTH && DEPTH >= 2)) begin : g_param_err
      $error("fifobuff_param: need AE_LVL < AF_LVL <= DEPTH and DEPTH >= 2");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   fifo_status_t      status;
   logic              wr_acc_c;

   fifo_ptr_ctrl #(
      .DEPTH  (DEPTH),
      .AF_LVL (AF_LVL),
      .AE_LVL (AE_LVL)
   ) u_ctrl (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .write    (write),
      .read     (read),
      .wr_ptr   (wr_ptr),
      .rd_ptr   (rd_ptr),
      .count    (count),
      .status   (status),
      .wr_acc_c (wr_acc_c)
   );

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_acc_c) mem[wr_ptr] <= wr_data;
   end

   assign full         = status.full;
   assign empty        = status.empty;
   assign almost_full  = status.almost_full;
   assign almost_empty = status.almost_empty;
   assign overflow     = status.overflow;
   assign underflow    = status.underflow;

   if (FWFT != 0) begin : g_fwft
      // Head word shown directly; masked to zero while empty so stale storage never leaks.
      assign rd_data  = status.empty ? '0 : mem[rd_ptr];
      assign rd_valid = ~status.empty;
   end else begin : g_reg
      always_ff @(posedge clk) begin
         if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
         end else if (flush) begin
            rd_valid <= 1'b0;
         end else begin
            rd_valid <= read & ~status.empty;
            if (read && !status.empty) rd_data <= mem[rd_ptr];
         end
      end
   end

endmodule

// File: tb/tb_fifobuff_param.sv
// Randomised scoreboard bench: an FWFT depth-8 FIFO and a registered-read depth-6 FIFO side by side.
module tb_fifobuff_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       write = 1'b0;
   logic       read = 1'b0;
   logic [2:0] wr_data = 3'd0;

   logic [2:0] rd_data0, rd_data1;
   logic       rd_valid0, rd_valid1;
   logic       full0, full1, empty0, empty1;
   logic       af0, af1, ae0, ae1;
   logic [3:0] count0;
   logic [2:0] count1;
   logic       ovf0, ovf1, unf0, unf1;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: contents as queues, expected read-out words as scoreboard queues.
   logic [2:0] mq0[$], mq1[$], eq0[$], eq1[$];
   int  dep[2] = '{8, 6};
   int  afl[2] = '{6, 4};
   int  ael[2] = '{1, 1};
   bit  m_ovf[2], m_unf[2];
   bit  last_pop1;

   fifobuff_param #(.DATA_W(3), .DEPTH(8), .AF_LVL(6), .AE_LVL(1), .FWFT(1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .write(write), .wr_data(wr_data), .read(read),
      .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .count(count0),
      .overflow(ovf0), .underflow(unf0)
   );

   fifobuff_param #(.DATA_W(3), .DEPTH(6), .AF_LVL(4), .AE_LVL(1), .FWFT(0)) u_dut_reg (
      .clk(clk), .rst(rst), .flush(flush), .write(write), .wr_data(wr_data), .read(read),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .count(count1),
      .overflow(ovf1), .underflow(unf1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic model_step(input int i, input bit w, input bit r, input logic [2:0] d,
                             input bit clr);
      int c;
      bit racc, wacc;
      logic [2:0] v;
      c = (i == 0) ? mq0.size() : mq1.size();
      if (i == 1) last_pop1 = 1'b0;
      if (clr) begin
         if (i == 0) mq0.delete(); else mq1.delete();
         m_ovf[i] = 1'b0;
         m_unf[i] = 1'b0;
         return;
      end
      racc = r && (c > 0);
      wacc = w && (c < dep[i] || racc);
      if (r && !racc) m_unf[i] = 1'b1;
      if (w && !wacc) m_ovf[i] = 1'b1;
      if (racc) begin
         if (i == 0) begin v = mq0.pop_front(); eq0.push_back(v); end
         else begin v = mq1.pop_front(); eq1.push_back(v); last_pop1 = 1'b1; end
      end
      if (wacc) begin
         if (i == 0) mq0.push_back(d); else mq1.push_back(d);
      end
   endtask

   task automatic check_state();
      int c0, c1;
      c0 = mq0.size();
      c1 = mq1.size();
      chk("count0",   32'(count0), 32'(c0));
      chk("full0",    32'(full0),  32'(c0 == dep[0]));
      chk("empty0",   32'(empty0), 32'(c0 == 0));
      chk("afull0",   32'(af0),    32'(c0 >= afl[0]));
      chk("aempty0",  32'(ae0),    32'(c0 <= ael[0]));
      chk("ovf0",     32'(ovf0),   32'(m_ovf[0]));
      chk("unf0",     32'(unf0),   32'(m_unf[0]));
      chk("rdvalid0", 32'(rd_valid0), 32'(c0 > 0));
      chk("count1",   32'(count1), 32'(c1));
      chk("full1",    32'(full1),  32'(c1 == dep[1]));
      chk("empty1",   32'(empty1), 32'(c1 == 0));
      chk("afull1",   32'(af1),    32'(c1 >= afl[1]));
      chk("aempty1",  32'(ae1),    32'(c1 <= ael[1]));
      chk("ovf1",     32'(ovf1),   32'(m_ovf[1]));
      chk("unf1",     32'(unf1),   32'(m_unf[1]));
      chk("rdvalid1", 32'(rd_valid1), 32'(last_pop1));
   endtask

   // One clock of stimulus: drive, advance the model, then check state after the edge.
   task automatic step(input bit w, input bit r, input logic [2:0] d,
                       input bit f = 1'b0, input bit rs = 1'b0);
      write = w; read = r; wr_data = d; flush = f; rst = rs;
      model_step(0, w, r, d, f || rs);
      model_step(1, w, r, d, f || rs);
      @(posedge clk);
      #1;
      check_state();
   endtask

   // Monitor: compare every word the DUTs present against the scoreboard queues.
   always @(negedge clk) begin
      logic [2:0] exp;
      if (!rst && !flush && read && rd_valid0 === 1'b1) begin
         if (eq0.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL fwft_pop at %0t: got data %0d expected no pop", $time, rd_data0);
         end else begin
            exp = eq0.pop_front();
            chk("fwft_data", 32'(rd_data0), 32'(exp));
         end
      end
      if (rd_valid1 === 1'b1) begin
         if (eq1.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL reg_pulse at %0t: got data %0d expected no pulse", $time, rd_data1);
         end else begin
            exp = eq1.pop_front();
            chk("reg_data", 32'(rd_data1), 32'(exp));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pw, pr;
      // Reset
      repeat (3) step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      chk("rst_rddata0", 32'(rd_data0), 32'd0);
      chk("rst_rddata1", 32'(rd_data1), 32'd0);

      // Push two, pop one
      step(1'b1, 1'b0, 3'b001);
      step(1'b1, 1'b0, 3'b010);
      step(1'b0, 1'b1, 3'd0);
      chk("after_pop_data0", 32'(rd_data0), 32'b010);

      // Drain then pop on empty, then push+pop on empty
      step(1'b0, 1'b1, 3'd0);
      step(1'b0, 1'b1, 3'd0);
      step(1'b1, 1'b1, 3'b101);
      step(1'b0, 1'b0, 3'd0);
      chk("retained_data0", 32'(rd_data0), 32'b101);

      // Fill past full, simultaneous push+pop at full, drain
      step(1'b0, 1'b0, 3'd0, 1'b1);
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 3'(i + 1));
      step(1'b1, 1'b1, 3'b111);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 3'd0);

      // Five entries with overflow set, then flush
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 3'(7 - i));
      repeat (3) step(1'b0, 1'b1, 3'd0);
      step(1'b1, 1'b1, 3'b011, 1'b1);
      step(1'b1, 1'b0, 3'b110);
      chk("post_flush_entry0", 32'(rd_data0), 32'b110);

      // Occupancy-3 streaming across pointer wrap
      step(1'b1, 1'b0, 3'b100);
      step(1'b1, 1'b0, 3'b001);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 3'($urandom));
      step(1'b1, 1'b0, 3'b010);
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);

      // Randomised traffic with varying read/write pressure, flushes and resets
      for (int blk = 0; blk < 12; blk++) begin
         pw = $urandom_range(20, 90);
         pr = $urandom_range(20, 90);
         for (int i = 0; i < 150; i++) begin
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 3'($urandom),
                 $urandom_range(0, 59) == 0, $urandom_range(0, 299) == 0);
         end
      end

      repeat (3) step(1'b0, 1'b0, 3'd0);
      chk("sb_empty0", 32'(eq0.size()), 32'd0);
      chk("sb_empty1", 32'(eq1.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
